// File: rtl/counter_pkg.sv
//============================================================================
// Package : counter_pkg
// Desc    : Shared mode encodings and types for the modulus counter slice.
// Rev     : 1.0
//============================================================================
`default_nettype none

package counter_pkg;

    localparam int unsigned MODE_W = 2;

    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t MODE_UP   = 2'b00;
    localparam mode_t MODE_DOWN = 2'b01;
    localparam mode_t MODE_STEP = 2'b10;
    localparam mode_t MODE_LOAD = 2'b11;

endpackage : counter_pkg

`default_nettype wire

// File: rtl/counter_next_val.sv
//============================================================================
// Module : counter_next_val
// Desc   : Combinational next-count, wrap and load-flag generation.
//          COUNTER_SAT_EN selects saturation instead of wrap for up/down/step.
// Rev    : 1.0
//============================================================================
`default_nettype none

module counter_next_val
    import counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MODV  = 2**WIDTH,
    parameter int STEP  = 3
) (
    input  logic [WIDTH-1:0] i_q,
    input  mode_t            i_modo,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_next_q,
    output logic             o_wrap,
    output logic             o_load
);

    // One extra bit so MODV = 2**WIDTH and Q+STEP are representable.
    typedef logic [WIDTH:0] ext_t;

    localparam ext_t             c_modv  = ext_t'(MODV);
    localparam ext_t             c_step  = ext_t'(STEP);
    localparam logic [WIDTH-1:0] c_max_q = WIDTH'(MODV - 1);

    ext_t w_q_ext;
    ext_t w_sum;

    assign w_q_ext = {1'b0, i_q};

    always_comb begin
        o_next_q = i_q;
        o_wrap   = 1'b0;
        o_load   = 1'b0;
        w_sum    = '0;
        case (i_modo)
            MODE_UP, MODE_STEP: begin
                w_sum = (i_modo == MODE_UP) ? (w_q_ext + ext_t'(1)) : (w_q_ext + c_step);
                if (w_sum >= c_modv) begin
                    o_wrap = 1'b1;
`ifdef COUNTER_SAT_EN
                    o_next_q = c_max_q;
`else
                    o_next_q = WIDTH'(w_sum - c_modv);
`endif
                end else begin
                    o_next_q = w_sum[WIDTH-1:0];
                end
            end
            MODE_DOWN: begin
                if (i_q == '0) begin
                    o_wrap = 1'b1;
`ifdef COUNTER_SAT_EN
                    o_next_q = '0;
`else
                    o_next_q = c_max_q;
`endif
                end else begin
                    o_next_q = i_q - WIDTH'(1);
                end
            end
            default: begin
                o_load   = 1'b1;
                o_next_q = ({1'b0, i_data} < c_modv) ? i_data : c_max_q;
            end
        endcase
    end

endmodule : counter_next_val

`default_nettype wire

// File: rtl/counter_mod_param.sv
//============================================================================
// Module : counter_mod_param
// Desc   : Parametrised modulus counter (up/down/step/load) with registered
//          rco and load strobes. COUNTER_SAT_EN selects saturating counts.
// Rev    : 1.0
//============================================================================
`default_nettype none

module counter_mod_param
    import counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MODV  = 2**WIDTH,
    parameter int STEP  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enb,
    input  mode_t            modo,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] Q,
    output logic             rco,
    output logic             load
);

    logic [WIDTH-1:0] r_q;
    logic             r_rco;
    logic             r_load;

    logic [WIDTH-1:0] w_next_q;
    logic             w_wrap;
    logic             w_load;

    counter_next_val #(
        .WIDTH (WIDTH),
        .MODV  (MODV),
        .STEP  (STEP)
    ) u_next_val (
        .i_q      (r_q),
        .i_modo   (modo),
        .i_data   (data),
        .o_next_q (w_next_q),
        .o_wrap   (w_wrap),
        .o_load   (w_load)
    );

    // Strobes are rewritten every edge, so a disabled edge clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= '0;
            r_rco  <= 1'b0;
            r_load <= 1'b0;
        end else if (enb) begin
            r_q    <= w_next_q;
            r_rco  <= w_wrap;
            r_load <= w_load;
        end else begin
            r_rco  <= 1'b0;
            r_load <= 1'b0;
        end
    end

    assign Q    = r_q;
    assign rco  = r_rco;
    assign load = r_load;

endmodule : counter_mod_param

`default_nettype wire

// File: doc/counter_mod_param.md
Name: counter_mod_param

Overview:
- Parametrised successor to the 4-bit mode counter.
- Counts within a configurable width and modulus.
- Four modes: up, down, up-by-STEP, parallel load.
- Registered wrap (rco) and load-acknowledge strobes for cascading and testbench checking. Sits directly under a probador wrapper, driven by a signal-generator testbench.

Parameters:
- WIDTH, 4, bit width of data and Q.
- MODV, 2**WIDTH, modulus; Q always in 0..MODV-1; legal range 2..2**WIDTH.
- STEP, 3, increment for step mode; legal range 1..MODV-1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- enb  in  1  count/load enable; sampled on rising clk.
- modo  in  2  mode: 00 up, 01 down, 10 up-by-STEP, 11 load.
- data  in  WIDTH  parallel load value, used only in mode 11.
- Q  out  WIDTH  registered count.
- rco  out  1  registered wrap strobe.
- load  out  1  registered load-acknowledge strobe.

Behaviour:
- Reset:
  - rst=1 forces Q=0, rco=0, load=0 immediately, independent of clk.
  - Reset wins over every other input.
  - Deassertion is synchronous-safe: the first count happens on the first rising edge with rst=0 and enb=1.
- All outputs are registered. Inputs sampled at edge k appear on Q/rco/load after edge k; latency is 1 cycle.
- enb=0: Q holds; rco=0 and load=0 on that edge, so strobes never last more than one cycle unless the event repeats.
- Arithmetic: next value is computed in WIDTH+1 bits so the sum never truncates before the modulus compare.
- Mode 00 (up):
  - Q+1 >= MODV gives Q<=0, rco<=1.
  - Otherwise Q<=Q+1, rco<=0.
- Mode 01 (down):
  - Q==0 gives Q<=MODV-1, rco<=1.
  - Otherwise Q<=Q-1, rco<=0.
- Mode 10 (step):
  - s=Q+STEP. If s >= MODV, Q<=s-MODV and rco<=1.
  - Otherwise Q<=s, rco<=0.
- Mode 11 (load):
  - Q<=data if data < MODV; otherwise Q<=MODV-1 (clamp).
  - load<=1, rco<=0.
  - In modes 00/01/10, load<=0.
- Consecutive enabled wrap or load cycles assert the corresponding strobe on every such edge.
- A mode change takes effect on the edge where it is sampled; there is no pipeline state to flush.
- Reset mid-operation discards any pending strobe.
- MODV = 2**WIDTH gives a plain binary wrap, with identical rco rules.

Optional Feature:
- Macro: COUNTER_SAT_EN.
- Defined:
  - Modes 00 and 10 saturate at MODV-1 instead of wrapping.
  - Mode 01 saturates at 0.
  - rco asserts for one cycle on each enabled edge where saturation blocked the full step; this includes the edge that reaches the limit by clamping and every edge that holds at the limit.
  - Load is unchanged.
- Undefined: wrap behaviour as specified above.

Decomposition:
- Shared package counter_pkg holds:
  - mode encodings MODE_UP=2'b00, MODE_DOWN=2'b01, MODE_STEP=2'b10, MODE_LOAD=2'b11;
  - the 2-bit mode typedef/width constant.
- One combinational sub-module, counter_next_val:
  - inputs: Q, modo, data;
  - outputs: next Q, wrap flag, load flag;
  - contains all modulus/clamp/saturation logic.
- The top holds only the registers, the enb gating and the async reset.

Test Plan (WIDTH=4, MODV=10, STEP=3 unless stated):
- Assert rst asynchronously between edges while Q=5 in mode 00 -> Q=0, rco=0, load=0 before the next edge. After release, 3 enabled up edges -> Q=3.
- From Q=0, mode 00, 10 enabled edges -> Q sequence 1..9 then 0; rco=1 only on the edge producing 0. Then mode 01, 1 edge -> Q=9, rco=1.
- Mode 11 with data=8 -> Q=8, load=1 for one cycle. Then mode 10 -> Q=1, rco=1; next edge Q=4, rco=0, load=0.
- Mode 11 with data=13 -> Q=9 (clamped), load=1. Then enb=0 for 3 edges in mode 00 -> Q holds 9, rco=0, load=0 throughout.
- WIDTH=4, MODV=16, STEP=5: load 14, mode 10 -> Q=3, rco=1. Mode 01 from Q=0 -> Q=15, rco=1.
- COUNTER_SAT_EN defined: load 8, mode 10 -> Q=9, rco=1; again -> Q=9, rco=1. Load 1, mode 01 twice -> Q=0 (rco=0), then Q=0 (rco=1).
